dbg_host_bridge: RTL and testbench
==================================

Name: dbg_host_bridge

Overview:
- Byte-stream front end for the on-chip debugger controller; sits directly upstream of it.
- Takes bytes from the UART receiver, assembles them into debugger commands and drives host_cmd/host_param/host_cmd_en.
- Captures host_result one cycle after each issue and returns it as 4 bytes to the UART transmitter.
- Every command gets exactly one 4-byte reply, so the host can stay in lockstep.

Parameters:
- TIMEOUT_CYCLES, 1000000: maximum idle cycles between parameter bytes before the partial command is discarded.
- CNT_W, 20: width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  system clock; single clock domain.
- rst  in  1  synchronous, active-high reset.
- rx_data  in  8  received byte.
- rx_valid  in  1  one-cycle strobe; rx_data is valid this cycle.
- tx_data  out  8  byte to transmit.
- tx_valid  out  1  tx_data is valid; held until accepted.
- tx_ready  in  1  transmitter accepts the byte when tx_valid && tx_ready.
- host_cmd  out  8  command code to the debugger controller.
- host_param  out  32  command parameter.
- host_cmd_en  out  1  one-cycle command strobe.
- host_result  in  32  registered result from the debugger controller; valid the cycle after host_cmd_en.
- overrun  out  1  sticky flag: a byte was dropped because it arrived outside IDLE/PARAM.

Behaviour:
- Reset values: tx_data=0, tx_valid=0, host_cmd=0, host_param=0, host_cmd_en=0, overrun=0, state=IDLE, counters=0.
- Framing:
  - First byte is the command.
  - If bit7 of the command is 1, four parameter bytes follow, little-endian (byte0 lands in param[7:0]).
  - If bit7 is 0, the command carries no parameter and host_param is driven 0.
- States:
  - IDLE: on rx_valid, latch cmd. If cmd[7] -> PARAM with byte index 0 and timeout counter 0; else -> ISSUE.
  - PARAM:
    - On rx_valid, store the byte at the current index and clear the timeout counter.
    - On index 3 -> ISSUE; otherwise the index increments.
    - Without rx_valid the counter increments; when it reaches TIMEOUT_CYCLES-1 -> IDLE, partial command discarded, nothing issued, no reply.
    - If rx_valid and timeout coincide, the byte wins.
  - ISSUE: host_cmd_en=1 for exactly this cycle -> CAPTURE.
  - CAPTURE: register host_result into the reply buffer, reply index=0 -> SEND.
  - SEND:
    - tx_valid=1 with tx_data = reply byte at the current index, little-endian.
    - On tx_valid && tx_ready, the index increments; after byte 3 is accepted -> IDLE with tx_valid=0 the following cycle.
    - tx_data is stable while tx_valid && !tx_ready.
- Latency:
  - Last input byte accepted at edge N -> host_cmd_en high in cycle N+1 -> result captured at end of N+2 -> tx_valid high from cycle N+3.
  - With tx_ready held high, the reply completes 4 cycles later.
- host_cmd and host_param hold their values from ISSUE until the next command is latched.
  - This keeps the combinational memory-read address stable through both the issue cycle and the capture cycle.
- Non-read commands (stop, cont, set breakpoint, reset, ...) reply 0x00000000, as returned by the controller.
- Overrun:
  - rx_valid in ISSUE, CAPTURE or SEND drops the byte and sets overrun.
  - overrun is cleared only by rst.
  - The dropped byte is never interpreted as a command.
- Reset mid-operation returns to IDLE the next cycle. Partial commands and pending reply bytes are discarded, and tx_valid deasserts immediately.
- No command-code validation: unknown codes are issued as-is and answered with whatever host_result returns (0).

Decomposition:
- Shared debugger package holds:
  - state encodings (IDLE/PARAM/ISSUE/CAPTURE/SEND);
  - the command codes shared with the debugger controller, e.g. CMD_STOP=0x01, CMD_SET_BP=0x85, CMD_READ_REG=0x86, CMD_READ_IMEM=0x8C, CMD_QUERY=0x0E;
  - the parameter-flag bit position (7).
- One sub-module is natural: dbg_reply_ser, a 32-bit little-endian to byte serializer with valid/ready. The FSM stays in the top.

Test Plan:
- No-param command: rx 0x01 -> one host_cmd_en pulse with host_cmd=0x01 and host_param=0; stub result 0 -> tx bytes 00 00 00 00.
- Param command: rx 0x86,0x1F,0x00,0x00,0x00 with stub returning 0xDEADBEEF the cycle after issue -> host_param=0x0000001F during issue; tx EF BE AD DE; host_cmd_en exactly 1 cycle at N+1.
- Backpressure: same read with tx_ready toggling 1-of-3 cycles -> tx_data stable while stalled; exactly 4 handshakes, bytes in order.
- Timeout: TIMEOUT_CYCLES=16; rx 0x85,0x34 then silence 20 cycles -> no host_cmd_en, no tx. Next rx 0x0E issues cleanly with host_cmd=0x0E.
- Overrun: send 0x0E, then inject rx 0x02 during SEND -> overrun=1, only one host_cmd_en, reply intact. overrun stays 1 until rst.
- Reset mid-PARAM and mid-SEND: rst for 1 cycle -> all outputs return to reset values next cycle; a subsequent 0x0A command works normally.

Source files
------------

// File: rtl/dbg_host_bridge_pkg.sv
// dbg_host_bridge_pkg: state encodings and command codes shared with the debugger controller
package dbg_host_bridge_pkg;
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PARAM,
    ST_ISSUE,
    ST_CAPTURE,
    ST_SEND
  } state_e;
  localparam logic [7:0] CMD_STOP      = 8'h01;
  localparam logic [7:0] CMD_SET_BP    = 8'h85;
  localparam logic [7:0] CMD_READ_REG  = 8'h86;
  localparam logic [7:0] CMD_READ_IMEM = 8'h8C;
  localparam logic [7:0] CMD_QUERY     = 8'h0E;
  localparam int PARAM_BIT = 7;
endpackage

// File: rtl/dbg_reply_ser.sv
// dbg_reply_ser: 32-bit word to little-endian byte stream with valid/ready
module dbg_reply_ser (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_i,
  input  logic [31:0] word_i,
  input  logic        ready_i,
  output logic [7:0]  data_o,
  output logic        valid_o,
  output logic        last_o
);
  logic [31:0] word_q;
  logic [1:0]  idx_q;
  logic        valid_q;
  assign data_o  = word_q[{idx_q, 3'b000} +: 8];
  assign valid_o = valid_q;
  assign last_o  = valid_q && ready_i && idx_q == 2'd3;
  // load a word, then step through its bytes on each accepted handshake
  always_ff @(posedge clk) begin
    if (rst) begin
      word_q  <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
    end else if (load_i) begin
      word_q  <= word_i;
      idx_q   <= '0;
      valid_q <= 1'b1;
    end else if (valid_q && ready_i) begin
      idx_q   <= idx_q + 2'd1;
      valid_q <= idx_q != 2'd3;
    end
  end
endmodule

// File: rtl/dbg_host_bridge.sv
// dbg_host_bridge: assembles UART bytes into debugger commands and returns 4-byte replies
module dbg_host_bridge
  import dbg_host_bridge_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int CNT_W          = 20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [7:0]  host_cmd,
  output logic [31:0] host_param,
  output logic        host_cmd_en,
  input  logic [31:0] host_result,
  output logic        overrun
);
  state_e           state_q;
  logic [7:0]       cmd_q;
  logic [23:0]      param_q;
  logic [1:0]       idx_q;
  logic [CNT_W-1:0] cnt_q;
  logic [7:0]       host_cmd_q;
  logic [31:0]      host_param_q;
  logic             host_cmd_en_q;
  logic             overrun_q;
  logic             ser_last;
  logic             busy;
  assign busy        = state_q inside {ST_ISSUE, ST_CAPTURE, ST_SEND};
  assign host_cmd    = host_cmd_q;
  assign host_param  = host_param_q;
  assign host_cmd_en = host_cmd_en_q;
  assign overrun     = overrun_q;
  // command framing FSM; host_cmd/host_param only change when a command is issued
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      cmd_q         <= '0;
      param_q       <= '0;
      idx_q         <= '0;
      cnt_q         <= '0;
      host_cmd_q    <= '0;
      host_param_q  <= '0;
      host_cmd_en_q <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      host_cmd_en_q <= 1'b0;
      case (state_q)
        ST_IDLE: if (rx_valid) begin
          cmd_q <= rx_data;
          idx_q <= '0;
          cnt_q <= '0;
          if (rx_data[PARAM_BIT]) state_q <= ST_PARAM;
          else begin
            host_cmd_q    <= rx_data;
            host_param_q  <= '0;
            host_cmd_en_q <= 1'b1;
            state_q       <= ST_ISSUE;
          end
        end
        ST_PARAM: if (rx_valid) begin
          cnt_q <= '0;
          if (idx_q == 2'd3) begin
            host_cmd_q    <= cmd_q;
            host_param_q  <= {rx_data, param_q};
            host_cmd_en_q <= 1'b1;
            state_q       <= ST_ISSUE;
          end else begin
            param_q <= {rx_data, param_q[23:8]};
            idx_q   <= idx_q + 2'd1;
          end
        end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) state_q <= ST_IDLE;
        else cnt_q <= cnt_q + 1'b1;
        ST_ISSUE:   state_q <= ST_CAPTURE;
        ST_CAPTURE: state_q <= ST_SEND;
        ST_SEND:    if (ser_last) state_q <= ST_IDLE;
        default:    state_q <= ST_IDLE;
      endcase
      if (rx_valid && busy) overrun_q <= 1'b1;
    end
  end
  dbg_reply_ser u_ser (
    .clk     (clk),
    .rst     (rst),
    .load_i  (state_q == ST_CAPTURE),
    .word_i  (host_result),
    .ready_i (tx_ready),
    .data_o  (tx_data),
    .valid_o (tx_valid),
    .last_o  (ser_last)
  );
endmodule

// File: tb/tb_dbg_host_bridge.sv
// tb_dbg_host_bridge: directed and randomized checks of command framing, replies, timeout, overrun, reset
module tb_dbg_host_bridge;
  import dbg_host_bridge_pkg::*;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  rx_data = '0;
  logic        rx_valid = 1'b0;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic [7:0]  host_cmd;
  logic [31:0] host_param;
  logic        host_cmd_en;
  logic [31:0] host_result = '0;
  logic        overrun;
  int          compared = 0;
  int          mismatched = 0;
  int          en_cnt = 0;
  int          mode = 0;
  int          phase = 0;
  int          e0;
  logic [31:0] next_result = '0;
  logic [7:0]  txq[$];
  logic        stall_prev = 1'b0;
  logic [7:0]  prev_data = '0;

  always #5 clk = ~clk;

  dbg_host_bridge #(.TIMEOUT_CYCLES(16), .CNT_W(5)) dut (
    .clk         (clk),
    .rst         (rst),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .host_cmd    (host_cmd),
    .host_param  (host_param),
    .host_cmd_en (host_cmd_en),
    .host_result (host_result),
    .overrun     (overrun)
  );

  // controller stub: result is only meaningful the cycle after the strobe
  always @(posedge clk) host_result <= host_cmd_en ? next_result : $urandom;

  // transmitter readiness: always, one cycle in three, or random
  initial forever begin
    @(posedge clk);
    #2;
    phase = (phase + 1) % 3;
    tx_ready = mode == 0 ? 1'b1 : mode == 1 ? (phase == 0) : 1'($urandom_range(0, 1));
  end

  // observe strobes, accepted bytes and stall stability
  always begin
    @(negedge clk);
    #1;
    if (host_cmd_en) en_cnt++;
    if (stall_prev) begin
      compared++;
      assert (tx_valid === 1'b1 && tx_data === prev_data) else begin
        mismatched++;
        $error("FAIL stall_hold: got valid=%b data=%h, expected valid=1 data=%h", tx_valid, tx_data, prev_data);
      end
    end
    if (tx_valid && tx_ready && !rst) txq.push_back(tx_data);
    stall_prev = tx_valid && !tx_ready && !rst;
    prev_data = tx_data;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    assert (got === exp) else begin
      mismatched++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    repeat (gap) @(negedge clk);
    @(negedge clk);
    rx_data = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    rx_data = 8'($urandom);
  endtask

  task automatic check_reset_vals();
    chk("rst_tx_data", 32'(tx_data), 0);
    chk("rst_tx_valid", 32'(tx_valid), 0);
    chk("rst_host_cmd", 32'(host_cmd), 0);
    chk("rst_host_param", host_param, 0);
    chk("rst_host_cmd_en", 32'(host_cmd_en), 0);
    chk("rst_overrun", 32'(overrun), 0);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_reset_vals();
    rst = 1'b0;
    txq.delete();
  endtask

  // issue one command and check issue timing, held outputs and the 4-byte reply
  task automatic run_cmd(input logic [7:0] cmd, input logic [31:0] param, input logic [31:0] result,
                         input int m, input bit inject);
    logic [31:0] exp_param;
    logic [31:0] got;
    int          start;
    int          iters;
    mode = m;
    next_result = result;
    txq.delete();
    start = en_cnt;
    exp_param = cmd[PARAM_BIT] ? param : 32'h0;
    send_byte(cmd, 0);
    if (cmd[PARAM_BIT]) for (int i = 0; i < 4; i++) send_byte(param[8*i +: 8], $urandom_range(0, 4));
    chk("issue_en", 32'(host_cmd_en), 1);
    chk("issue_cmd", 32'(host_cmd), 32'(cmd));
    chk("issue_param", host_param, exp_param);
    @(negedge clk);
    chk("en_one_cycle", 32'(host_cmd_en), 0);
    chk("hold_cmd", 32'(host_cmd), 32'(cmd));
    chk("hold_param", host_param, exp_param);
    chk("no_tx_early", 32'(tx_valid), 0);
    @(negedge clk);
    chk("tx_start", 32'(tx_valid), 1);
    chk("tx_first", 32'(tx_data), 32'(result[7:0]));
    #2;
    iters = 0;
    while (txq.size() < 4 && iters < 300) begin
      if (inject && iters == 0) begin
        rx_data = 8'h02;
        rx_valid = 1'b1;
      end else rx_valid = 1'b0;
      @(negedge clk);
      #2;
      iters++;
    end
    rx_valid = 1'b0;
    chk("reply_count", 32'(txq.size()), 4);
    if (m == 0) chk("reply_latency", 32'(iters), 3);
    got = txq.size() >= 4 ? {txq[3], txq[2], txq[1], txq[0]} : 32'hxxxxxxxx;
    chk("reply_bytes", got, result);
    @(negedge clk);
    chk("tx_idle_after", 32'(tx_valid), 0);
    chk("issue_count", 32'(en_cnt - start), 1);
  endtask

  initial begin
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_vals();
    rst = 1'b0;
    run_cmd(CMD_STOP, 32'hFFFF_FFFF, 32'h0, 0, 0);
    run_cmd(CMD_READ_REG, 32'h0000_001F, 32'hDEAD_BEEF, 0, 0);
    run_cmd(CMD_READ_REG, 32'h0000_001F, 32'hDEAD_BEEF, 1, 0);
    for (int k = 0; k < 10; k++)
      run_cmd(8'($urandom), $urandom, $urandom, $urandom_range(0, 2), 0);
    chk("no_overrun_yet", 32'(overrun), 0);
    mode = 0;
    txq.delete();
    e0 = en_cnt;
    send_byte(CMD_SET_BP, 0);
    send_byte(8'h34, 0);
    repeat (20) @(negedge clk);
    #2;
    chk("timeout_no_issue", 32'(en_cnt - e0), 0);
    chk("timeout_no_tx", 32'(txq.size()), 0);
    chk("timeout_tx_valid", 32'(tx_valid), 0);
    run_cmd(CMD_QUERY, 32'h0, $urandom, 0, 0);
    run_cmd(CMD_QUERY, 32'h0, 32'h1234_5678, 0, 1);
    chk("overrun_set", 32'(overrun), 1);
    run_cmd(CMD_READ_IMEM, $urandom, $urandom, 2, 0);
    chk("overrun_sticky", 32'(overrun), 1);
    send_byte(CMD_READ_REG, 0);
    send_byte(8'h11, 0);
    pulse_reset();
    run_cmd(8'h0A, 32'h0, $urandom, 0, 0);
    mode = 1;
    next_result = $urandom;
    send_byte(CMD_READ_IMEM, 0);
    for (int i = 0; i < 4; i++) send_byte(8'($urandom), 0);
    repeat (5) @(negedge clk);
    chk("mid_send_valid", 32'(tx_valid), 1);
    pulse_reset();
    run_cmd(8'h0A, 32'h0, $urandom, 2, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
